// File: rtl/sseg_scan.sv
// -----------------------------------------------------------------------------
// sseg_scan
// Time-multiplexed driver for a four-digit seven-segment display.
//
// A 16-bit hex value plus four decimal points is scanned onto a rotating
// active-low anode strobe and an active-low segment bus. Every digit slot is
// preceded by a dark gap so the previous digit's segments never ghost onto the
// next anode. New values are only applied at the frame boundary, so one frame
// never shows a mix of old and new data.
//
// Optional feature macro: SSEG_LEADING_ZERO_BLANK_EN
//   defined     : digits 3..1 go dark when they and all higher nibbles are 0
//   not defined : all four digits always decode
//
// Parameters
//   PRESCALE     cycles each digit is lit (>= 1)
//   BLANK_CYCLES cycles all digits are dark before each digit slot (>= 1)
//
// Ports
//   OSCCLK  in   1  system clock
//   reset   in   1  synchronous, active-high reset
//   value   in  16  hex value, nibble i -> digit i
//   dp      in   4  decimal point enables, active-high, dp[i] -> digit i
//   load    in   1  one-cycle strobe capturing value/dp
//   an      out  4  digit anodes, active-low (one low or all high)
//   sseg    out  8  segments, active-low, bit0 = a .. bit6 = g, bit7 = dp
//
// State table
//   state    | meaning
//   ST_BLANK | all anodes high, segments dark, counting BLANK_CYCLES
//   ST_ON    | anode idx low, segments show digit idx, counting PRESCALE
// -----------------------------------------------------------------------------
module sseg_scan #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        OSCCLK,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        load,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    localparam int MAX_CYC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    // A width of zero is not representable, so a single-cycle timer keeps one bit.
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] ON_TC    = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp_val;
    logic [3:0]    disp_dp;
    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;
    logic          pending;
    logic          frame_end;

    // Hex to active-low segments g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Full segment byte for digit i of the given display contents.
    function automatic logic [7:0] digit_seg(input logic [1:0]  i,
                                             input logic [15:0] v,
                                             input logic [3:0]  d);
        logic [3:0] nib;
        logic [6:0] seg;
        nib = v[{i, 2'b00} +: 4];
        seg = hex_to_seg(nib);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit above it are 0.
        case (i)
            2'd1:    if (v[15:4]  == 12'h000) seg = 7'h7F;
            2'd2:    if (v[15:8]  == 8'h00)   seg = 7'h7F;
            2'd3:    if (v[15:12] == 4'h0)    seg = 7'h7F;
            default: ;
        endcase
`endif
        return {~d[i], seg};
    endfunction

    // Digit 3's ON period ends on this edge and the scan wraps to digit 0.
    assign frame_end = (state == ST_ON) && (cnt == ON_TC) && (idx == 2'd3);

    always_ff @(posedge OSCCLK) begin
        if (reset) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            disp_val   <= 16'h0000;
            disp_dp    <= 4'h0;
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
            pending    <= 1'b0;
            an         <= 4'b1111;
            sseg       <= 8'hFF;
        end else begin
            // A load on the boundary edge bypasses the shadow and wins over
            // anything already pending.
            if (frame_end) begin
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp;
                end else if (pending) begin
                    disp_val <= shadow_val;
                    disp_dp  <= shadow_dp;
                end
                pending <= 1'b0;
            end else if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
                pending    <= 1'b1;
            end

            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_TC) begin
                        state <= ST_ON;
                        cnt   <= '0;
                        an    <= ~(4'b0001 << idx);
                        // The display register only changes while blanked,
                        // so the value latched here stays valid for the slot.
                        sseg  <= digit_seg(idx, disp_val, disp_dp);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ON: begin
                    if (cnt == ON_TC) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                        idx   <= idx + 2'd1;
                        an    <= 4'b1111;
                        sseg  <= 8'hFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                    an    <= 4'b1111;
                    sseg  <= 8'hFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_scan.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan
// Bench for sseg_scan with PRESCALE=4, BLANK_CYCLES=2. The reference model
// tracks edges since reset release and the value on display; expected anode
// and segment outputs follow from the position inside the frame.
// -----------------------------------------------------------------------------
module tb_sseg_scan;

    localparam int P = 4;
    localparam int B = 2;
    localparam int S = P + B;
    localparam int F = 4 * S;

    logic        OSCCLK = 1'b0;
    logic        reset  = 1'b1;
    logic        load   = 1'b0;
    logic [15:0] value  = 16'h0000;
    logic [3:0]  dp     = 4'h0;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          k      = 0;
    logic [19:0] m_disp = 20'h0;
    logic [19:0] m_pend = 20'h0;
    bit          m_has  = 1'b0;

    logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sseg_scan #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .OSCCLK (OSCCLK),
        .reset  (reset),
        .value  (value),
        .dp     (dp),
        .load   (load),
        .an     (an),
        .sseg   (sseg)
    );

    always #5 OSCCLK = ~OSCCLK;

    task automatic expected(output logic [3:0] ea, output logic [7:0] es);
        int p, slot, off;
        logic [15:0] v;
        logic [6:0]  seg;
        p    = k % F;
        slot = p / S;
        off  = p % S;
        v    = m_disp[15:0];
        if (off < B) begin
            ea = 4'b1111;
            es = 8'hFF;
        end else begin
            ea  = ~(4'b0001 << slot);
            seg = dec[(v >> (slot * 4)) & 16'hF];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
            if (slot > 0 && (v >> (slot * 4)) == 16'h0) seg = 7'h7F;
`endif
            es = {~m_disp[16 + slot], seg};
        end
    endtask

    task automatic step(input bit r, input bit l, input logic [15:0] v, input logic [3:0] d);
        logic [3:0] ea;
        logic [7:0] es;
        reset = r;
        load  = l;
        value = v;
        dp    = d;
        @(posedge OSCCLK);
        if (r) begin
            k      = 0;
            m_disp = 20'h0;
            m_pend = 20'h0;
            m_has  = 1'b0;
        end else begin
            k = k + 1;
            if (k % F == 0) begin
                if (l) m_disp = {d, v};
                else if (m_has) m_disp = m_pend;
                m_has = 1'b0;
            end else if (l) begin
                m_pend = {d, v};
                m_has  = 1'b1;
            end
        end
        #1;
        expected(ea, es);
        checks++;
        assert (an === ea) else begin
            errors++;
            $error("FAIL an k=%0d observed %b expected %b", k, an, ea);
        end
        checks++;
        assert (sseg === es) else begin
            errors++;
            $error("FAIL sseg k=%0d observed %h expected %h", k, sseg, es);
        end
        checks++;
        assert (an == 4'b1111 || $countones(~an) == 1) else begin
            errors++;
            $error("FAIL an_onehot k=%0d observed %b expected one low or none", k, an);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    // Advance until the model position in the frame equals pos.
    task automatic run_to(input int pos);
        for (int i = 0; i < F && (k % F) != pos; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    logic [7:0] scan_exp [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};

    initial begin
        // Reset for 3 cycles; the load on the last reset cycle is discarded.
        step(1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 16'hFFFF, 4'hF);
        checks++;
        assert (an === 4'b1111 && sseg === 8'hFF) else begin
            errors++;
            $error("FAIL reset_out observed %b/%h expected 1111/ff", an, sseg);
        end
        idle(B - 1);
        checks++;
        assert (an === 4'b1111) else begin
            errors++;
            $error("FAIL blank_after_reset observed %b expected 1111", an);
        end
        idle(1);
        checks++;
        assert (an === 4'b1110 && sseg === 8'hC0) else begin
            errors++;
            $error("FAIL first_on observed %b/%h expected 1110/c0", an, sseg);
        end
        idle(F);

        // Scan order and segment values.
        step(1'b0, 1'b1, 16'h12AF, 4'b0100);
        run_to(0);
        idle(F);
        for (int s = 0; s < 4; s++) begin
            run_to(B + s * S);
            checks++;
            assert (sseg === scan_exp[s]) else begin
                errors++;
                $error("FAIL scan_digit%0d observed %h expected %h", s, sseg, scan_exp[s]);
            end
        end

        // Frame coherency: load during digit 1 ON.
        run_to(S + B + 1);
        step(1'b0, 1'b1, 16'h0000, 4'h0);
        run_to(3 * S + B);
        checks++;
        assert (sseg === 8'hF9) else begin
            errors++;
            $error("FAIL coherency_old observed %h expected f9", sseg);
        end
        run_to(B);
        checks++;
        assert (sseg === 8'hC0) else begin
            errors++;
            $error("FAIL coherency_new observed %h expected c0", sseg);
        end

        // Two loads in one frame: latest wins.
        run_to(3);
        step(1'b0, 1'b1, 16'h1111, 4'h0);
        run_to(10);
        step(1'b0, 1'b1, 16'h2222, 4'h0);
        run_to(B);
        checks++;
        assert (sseg === 8'hA4) else begin
            errors++;
            $error("FAIL latest_wins observed %h expected a4", sseg);
        end

        // Load exactly on the boundary edge.
        run_to(F - 1);
        step(1'b0, 1'b1, 16'h7E3C, 4'b1001);
        run_to(B);
        checks++;
        assert (sseg === 8'h46) else begin
            errors++;
            $error("FAIL boundary_load observed %h expected 46", sseg);
        end
        idle(F);

        // Random loads.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0)
                step(1'b0, 1'b1, 16'($urandom), 4'($urandom));
            else
                idle(1);
        end

        // Reset mid-scan during digit 2 ON.
        run_to(2 * S + B + 1);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        checks++;
        assert (an === 4'b1111) else begin
            errors++;
            $error("FAIL reset_midscan observed %b expected 1111", an);
        end
        idle(2 * F);

        // Leading-zero case.
        step(1'b0, 1'b1, 16'h0050, 4'h0);
        run_to(0);
        idle(F);
        step(1'b0, 1'b1, 16'h0000, 4'hF);
        run_to(0);
        idle(F);
        step(1'b0, 1'b1, 16'h0A00, 4'h2);
        run_to(0);
        idle(F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan.md
# sseg_scan

Time-multiplexed driver for a four-digit seven-segment display. Converts a 16-bit hex value plus per-digit decimal points into a rotating active-low anode strobe `an[3:0]` and an active-low segment bus `sseg[7:0]`. Sits directly upstream of the board top level, which demultiplexes `an`/`sseg` onto the four per-digit segment outputs. Inserts a blanking gap between digits to prevent ghosting, and applies new values only at frame boundaries so a frame never shows mixed data.

## Interface
- `PRESCALE`, default 50000: cycles each digit is lit (1 ms at 50 MHz); must be ≥1.
- `BLANK_CYCLES`, default 500: cycles all digits are dark before each digit slot; must be ≥1.

- `OSCCLK`  in  1  system clock; the only clock.
- `reset`  in  1  reset, synchronous, active-high.
- `value`  in  16  hex value; nibble *i* goes to digit *i*. Digit 0 = `value[3:0]`, strobed by `an[0]`.
- `dp`  in  4  decimal point enables, active-high; `dp[i]` applies to digit *i*.
- `load`  in  1  one-cycle strobe that captures `value` and `dp`.
- `an`  out  4  digit anodes, active-low, one-hot-low or all high.
- `sseg`  out  8  segments, active-low. Bit 0 = a … bit 6 = g, bit 7 = dp.

## Operation
- **Capture.** On `load`, `value`/`dp` are latched into a shadow register and `pending` is set. A later `load` before transfer overwrites the shadow (latest wins).
- **Transfer.** At the frame boundary, the display register takes the shadow value if `pending`, and `pending` clears. If `load` is asserted in the boundary cycle, that cycle's `value`/`dp` go straight to the display register and `pending` stays clear.
- **Frame boundary.** The clock edge where digit 3's ON period ends and the digit index wraps to 0.
- **State machine** (counter `cnt`, digit index `idx` 0..3):
  - BLANK: `an`=4'b1111, `sseg`=8'hFF. After `BLANK_CYCLES` cycles, go to ON.
  - ON: `an[idx]`=0 (others 1), `sseg` = decode of display nibble `idx`, with `sseg[7]` = ~dp[`idx`]. After `PRESCALE` cycles, go to BLANK with `idx` ← `idx`+1 mod 4.
- **Decode** (hex→`sseg[6:0]`, active-low), listed as digit:code:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- **Counter width.** `cnt` width is $clog2(max(PRESCALE, BLANK_CYCLES)). It resets to 0 on every state change.
- **Reset.** State BLANK, `cnt`=0, `idx`=0, display register 0, shadow 0, `pending`=0, `an`=4'b1111, `sseg`=8'hFF.
  - Reset mid-scan takes effect on the next edge regardless of state.
  - A `load` coincident with `reset` is discarded.

## Timing
- `an` and `sseg` are registered and update on the same edge as the state/`idx` transition. There are no combinational paths from inputs to outputs.
- Frame period is 4·(`BLANK_CYCLES`+`PRESCALE`) cycles.
- After reset deasserts, `an` first goes low (`an`=4'b1110) at the end of cycle `BLANK_CYCLES`.
- `load`-to-display latency ranges from 1 cycle (load at the boundary) to one full frame.
- Exactly one anode is low during ON. No two anodes are ever low simultaneously, including across transitions.

## Configuration
- **`SSEG_LEADING_ZERO_BLANK_EN` defined:**
  - Digits 3, 2 and 1 show `sseg[6:0]`=7'h7F (dark) when their nibble and all higher nibbles of the display register are zero.
  - Digit 0 always shows.
  - The decimal point is unaffected by blanking.
  - Anode timing is unchanged.
- **Not defined:** all four digits always decode, including leading zeros.

## Test plan
- **Reset.** Hold `reset` for 3 cycles → `an`=4'b1111 and `sseg`=8'hFF during reset and for `BLANK_CYCLES` cycles after.
- **Scan order.** `PRESCALE`=4, `BLANK_CYCLES`=2, then `load` 16'h12AF with `dp`=4'b0100:
  - Anode sequence is 1110, 1101, 1011, 0111, each low for 4 cycles with 2 dark cycles between.
  - Segment values in the second frame are 8'h8E, 8'h88, 8'h24 (dp on at digit 2), 8'hF9.
- **Frame coherency.** Pulse `load` 16'h0000 during digit 1 ON → digits 2 and 3 of the current frame still show the old value. The new value appears from digit 0 of the next frame.
- **Boundary collisions.**
  - Two `load`s in one frame (16'h1111 then 16'h2222) → the next frame shows 2222 only.
  - `load` exactly on the boundary edge → that value shows in the immediately following frame.
- **Reset mid-scan.** Assert `reset` during digit 2 ON → next edge `an`=4'b1111. Rescan restarts at digit 0 and shows 0000.
- **Leading-zero blanking.** With `SSEG_LEADING_ZERO_BLANK_EN`, load 16'h0050 → digits 3 and 2 show 8'hFF, digit 1 shows 8'h92, digit 0 shows 8'hC0. Without the macro, digits 3 and 2 show 8'hC0.
